// File: rtl/qam16_upsample_mapper_pkg.sv
// ============================================================================
// Module  : qam16_upsample_mapper_pkg
// Brief   : Shared 16-QAM level constants, Gray bit assignments and helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package qam16_upsample_mapper_pkg;

  localparam int C_SAMPLE_W = 18;     // 1s17
  localparam int C_LVL_A    = 32768;  // 0.25
  localparam int C_LVL_3A   = 98304;  // 0.75

  localparam logic [1:0] C_GRAY_M3A = 2'b00;
  localparam logic [1:0] C_GRAY_M1A = 2'b01;
  localparam logic [1:0] C_GRAY_P1A = 2'b11;
  localparam logic [1:0] C_GRAY_P3A = 2'b10;

  function automatic int phase_width(input int upsample);
    return (upsample <= 1) ? 1 : $clog2(upsample);
  endfunction

endpackage

`default_nettype wire

// File: rtl/qam16_gray_map.sv
// ============================================================================
// Module  : qam16_gray_map
// Brief   : Combinational Gray-coded 2-bit to signed 16-QAM axis level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qam16_gray_map
  import qam16_upsample_mapper_pkg::*;
#(
  parameter int OUT_W = C_SAMPLE_W
) (
  input  logic        [1:0]       sym_bits,
  output logic signed [OUT_W-1:0] level
);

  localparam logic signed [OUT_W-1:0] c_neg_3a = OUT_W'(-C_LVL_3A);
  localparam logic signed [OUT_W-1:0] c_neg_a  = OUT_W'(-C_LVL_A);
  localparam logic signed [OUT_W-1:0] c_pos_a  = OUT_W'(C_LVL_A);
  localparam logic signed [OUT_W-1:0] c_pos_3a = OUT_W'(C_LVL_3A);

  always_comb begin
    level = c_neg_3a;
    case (sym_bits)
      C_GRAY_M3A: level = c_neg_3a;
      C_GRAY_M1A: level = c_neg_a;
      C_GRAY_P1A: level = c_pos_a;
      C_GRAY_P3A: level = c_pos_3a;
      default:    level = c_neg_3a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/qam16_upsample_mapper.sv
// ============================================================================
// Module  : qam16_upsample_mapper
// Brief   : Symbol-rate strobe generation, 16-QAM mapping and upsampling
//           (zero-stuff or hold) of LFSR payload symbols.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qam16_upsample_mapper
  import qam16_upsample_mapper_pkg::*;
#(
  parameter int UPSAMPLE   = 4,
  parameter int ZERO_STUFF = 1,
  parameter int OUT_W      = C_SAMPLE_W,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic        [3:0]       sym_in,
  output logic                    sym_clk_en,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    sym_strobe,
  output logic        [CNT_W-1:0] sym_count
);

  localparam int PH_W = phase_width(UPSAMPLE);
  localparam logic [PH_W-1:0] c_phase_last = PH_W'(UPSAMPLE - 1);

  logic        [PH_W-1:0]  r_phase;
  logic signed [OUT_W-1:0] r_i;
  logic signed [OUT_W-1:0] r_q;
  logic                    r_strobe;
  logic        [CNT_W-1:0] r_count;

  logic signed [OUT_W-1:0] w_lvl_i;
  logic signed [OUT_W-1:0] w_lvl_q;
  logic signed [OUT_W-1:0] w_fill_i;
  logic signed [OUT_W-1:0] w_fill_q;
  logic                    w_sym_edge;

  qam16_gray_map #(.OUT_W(OUT_W)) u_map_i (.sym_bits(sym_in[3:2]), .level(w_lvl_i));
  qam16_gray_map #(.OUT_W(OUT_W)) u_map_q (.sym_bits(sym_in[1:0]), .level(w_lvl_q));

  generate
    if (ZERO_STUFF != 0) begin : g_zero_stuff
      assign w_fill_i = '0;
      assign w_fill_q = '0;
    end else begin : g_hold
      assign w_fill_i = r_i;
      assign w_fill_q = r_q;
    end
  endgenerate

  // Combinational so the LFSR advances on the edge that closes the symbol.
  assign sym_clk_en = enable && (r_phase == c_phase_last);
  assign w_sym_edge = enable && (r_phase == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (enable) begin
      if (r_phase == c_phase_last) r_phase <= '0;
      else                         r_phase <= r_phase + PH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i      <= '0;
      r_q      <= '0;
      r_strobe <= 1'b0;
      r_count  <= '0;
    end else if (w_sym_edge) begin
      r_i      <= w_lvl_i;
      r_q      <= w_lvl_q;
      r_strobe <= 1'b1;
      r_count  <= r_count + CNT_W'(1);
    end else if (enable) begin
      r_i      <= w_fill_i;
      r_q      <= w_fill_q;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  assign i_out      = r_i;
  assign q_out      = r_q;
  assign sym_strobe = r_strobe;
  assign sym_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_qam16_upsample_mapper.sv
// ============================================================================
// Module  : tb_qam16_upsample_mapper
// Brief   : Scoreboard bench for three mapper configurations sharing stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_qam16_upsample_mapper;

  localparam int NDUT = 3;
  localparam int P_U  [NDUT] = '{4, 1, 3};
  localparam int P_ZS [NDUT] = '{1, 0, 0};
  localparam int P_CM [NDUT] = '{65536, 16, 256};
  localparam int LVL  [4]    = '{-98304, -32768, 98304, 32768};

  typedef struct {
    int d;
    int i;
    int q;
    int c;
    bit s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] sym_in = 4'hF;

  logic               ce_a, ce_b, ce_c;
  logic               st_a, st_b, st_c;
  logic signed [17:0] i_a, q_a, i_b, q_b, i_c, q_c;
  logic [15:0]        c_a;
  logic [3:0]         c_b;
  logic [7:0]         c_c;

  int   act_i  [NDUT];
  int   act_q  [NDUT];
  int   act_c  [NDUT];
  logic act_s  [NDUT];
  logic act_ce [NDUT];

  int   m_n [NDUT];
  int   m_i [NDUT];
  int   m_q [NDUT];
  int   m_c [NDUT];
  bit   m_s [NDUT];

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  qam16_upsample_mapper #(.UPSAMPLE(4), .ZERO_STUFF(1), .OUT_W(18), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sym_in(sym_in), .sym_clk_en(ce_a),
    .i_out(i_a), .q_out(q_a), .sym_strobe(st_a), .sym_count(c_a));
  qam16_upsample_mapper #(.UPSAMPLE(1), .ZERO_STUFF(0), .OUT_W(18), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sym_in(sym_in), .sym_clk_en(ce_b),
    .i_out(i_b), .q_out(q_b), .sym_strobe(st_b), .sym_count(c_b));
  qam16_upsample_mapper #(.UPSAMPLE(3), .ZERO_STUFF(0), .OUT_W(18), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .sym_in(sym_in), .sym_clk_en(ce_c),
    .i_out(i_c), .q_out(q_c), .sym_strobe(st_c), .sym_count(c_c));

  assign act_i[0] = int'(i_a);  assign act_q[0] = int'(q_a);
  assign act_i[1] = int'(i_b);  assign act_q[1] = int'(q_b);
  assign act_i[2] = int'(i_c);  assign act_q[2] = int'(q_c);
  assign act_c[0] = int'(c_a);  assign act_c[1] = int'(c_b);  assign act_c[2] = int'(c_c);
  assign act_s[0] = st_a;       assign act_s[1] = st_b;       assign act_s[2] = st_c;
  assign act_ce[0] = ce_a;      assign act_ce[1] = ce_b;      assign act_ce[2] = ce_c;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one sample period and predicts what the DUTs show after its edge.
  task automatic cycle(input bit r, input bit en, input logic [3:0] s);
    @(negedge clk);
    reset  = r;
    enable = en;
    sym_in = s;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      if (r) begin
        m_n[d] = 0; m_i[d] = 0; m_q[d] = 0; m_c[d] = 0; m_s[d] = 1'b0;
        check($sformatf("reset_i_dut%0d", d), act_i[d], 0);
        check($sformatf("reset_q_dut%0d", d), act_q[d], 0);
        check($sformatf("reset_cnt_dut%0d", d), act_c[d] + int'(act_s[d]), 0);
      end
      check($sformatf("sym_clk_en_dut%0d", d), int'(act_ce[d]),
            int'(en && (m_n[d] == P_U[d] - 1)));
      if (!r && en) begin
        if (m_n[d] == 0) begin
          m_i[d] = LVL[s[3:2]];
          m_q[d] = LVL[s[1:0]];
          m_s[d] = 1'b1;
          m_c[d] = (m_c[d] + 1) % P_CM[d];
        end else begin
          m_s[d] = 1'b0;
          if (P_ZS[d] != 0) begin
            m_i[d] = 0;
            m_q[d] = 0;
          end
        end
        m_n[d] = (m_n[d] + 1) % P_U[d];
      end else if (!r) begin
        m_s[d] = 1'b0;
      end
      sb.push_back('{d, m_i[d], m_q[d], m_c[d], m_s[d]});
    end
  endtask

  // Monitor: every clock presents one sample per DUT; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          total++;
          if (act_i[e.d] != e.i || act_q[e.d] != e.q ||
              act_c[e.d] != e.c || act_s[e.d] != e.s) begin
            bad++;
            $display("FAIL sample_dut%0d: got i=%0d q=%0d strobe=%0b cnt=%0d expected i=%0d q=%0d strobe=%0b cnt=%0d t=%0t",
                     e.d, act_i[e.d], act_q[e.d], act_s[e.d], act_c[e.d],
                     e.i, e.q, e.s, e.c, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_n[d] = 0; m_i[d] = 0; m_q[d] = 0; m_c[d] = 0; m_s[d] = 1'b0;
    end

    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 4'hF);

    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, 4'b1001);
    @(posedge clk); #2;
    check("count_after_12_u4", act_c[0], 3);
    check("count_after_12_u1", act_c[1], 12);
    check("count_after_12_u3", act_c[2], 4);

    for (int v = 0; v < 16; v++)
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 4'(v));

    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b1, 4'($urandom));
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 4'($urandom));
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 4'($urandom));

    cycle(1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 25; k++) cycle(1'b0, 1'b1, 4'($urandom));
    @(posedge clk); #2;
    check("count_before_reset", act_c[0], 7);
    cycle(1'b1, 1'b1, 4'($urandom));
    cycle(1'b0, 1'b1, 4'hE);
    @(posedge clk); #2;
    check("count_after_release", act_c[0], 1);
    check("strobe_after_release", int'(act_s[0]), 1);
    check("i_after_release", act_i[0], 32768);
    check("q_after_release", act_q[0], 98304);

    for (int k = 0; k < 600; k++)
      cycle($urandom_range(99) == 0, $urandom_range(3) != 0, 4'($urandom));

    @(posedge clk); #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
